// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter sequencer for the pipelined core. Owns the PC register and
// decides each cycle whether the PC holds, increments or loads, and from
// which source. Handles multi-byte instructions, a fixed memory-wait latency
// for stack pops (RET/RTI), prioritised interrupt vectors and a handshake for
// late JMP/CALL targets from decode.
//
// Optional feature (compile-time macro PC_EPC_EN):
//   defined   -> adds output epc_o, the return address captured when an
//                interrupt vector is taken.
//   undefined -> epc_o port and its register are absent.
//
// Ports:
//   clk_i           core clock, rising edge
//   reset_i         synchronous, active-high reset
//   irq_i           level interrupt requests, bit 0 highest priority
//   opcode_i        decoded opcode of the current fetch byte
//   brx_i           branch sub-op for opcode 11: 0 JMP, 1 CALL, 2 RET, 3 RTI
//   extra_bytes_i   operand bytes following this opcode
//   branch_taken_i  conditional branch / LOOP resolved taken in EX
//   tgt_ready_i     JMP/CALL target on rb_d_i is valid
//   rb_ex_i         branch target from EX
//   rb_d_i          JMP/CALL target from decode
//   mem_data_i      popped return address
//   vec_data_i      memory word at vector slot vec_idx_o
//   pc_o            current program counter
//   pc_en_o         PC updates this cycle
//   pc_load_o       PC update is a load rather than an increment
//   pc_src_o        load source: 00 rb_ex, 01 vector, 10 rb_d, 11 mem_data
//   vec_idx_o       vector slot: 0 reset, k for irq line k-1
//   irq_ack_o       one-hot, one-cycle interrupt acknowledge
//   stall_o         freeze upstream pipeline stages
//   epc_o           (PC_EPC_EN only) saved return address of last interrupt
// ----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int ADDR_W    = 8,
    parameter int MEM_LAT   = 2,   // 1..15
    parameter int MAX_EXTRA = 1,   // 1..3
    parameter int NUM_IRQ   = 1    // 1..7
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [3:0]        opcode_i,
    input  logic [1:0]        brx_i,
    input  logic [1:0]        extra_bytes_i,
    input  logic              branch_taken_i,
    input  logic              tgt_ready_i,
    input  logic [ADDR_W-1:0] rb_ex_i,
    input  logic [ADDR_W-1:0] rb_d_i,
    input  logic [ADDR_W-1:0] mem_data_i,
    input  logic [ADDR_W-1:0] vec_data_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pc_en_o,
    output logic              pc_load_o,
    output logic [1:0]        pc_src_o,
    output logic [2:0]        vec_idx_o,
    output logic [NUM_IRQ-1:0] irq_ack_o,
    output logic              stall_o
`ifdef PC_EPC_EN
    ,
    output logic [ADDR_W-1:0] epc_o
`endif
);

    localparam logic [2:0] S_VECTOR  = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_OPERAND = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_BRANCH  = 3'd4;

    localparam logic [3:0] OP_BRX  = 4'd11;
    localparam logic [1:0] SRC_EX  = 2'b00;
    localparam logic [1:0] SRC_VEC = 2'b01;
    localparam logic [1:0] SRC_D   = 2'b10;
    localparam logic [1:0] SRC_MEM = 2'b11;

    localparam logic [1:0] MAX_EXTRA_C = 2'(MAX_EXTRA);
    localparam logic [3:0] MEM_LAT_C   = 4'(MEM_LAT);

    logic [2:0]        state_q,   state_d;
    logic [ADDR_W-1:0] pc_q,      pc_d;
    logic [2:0]        vec_idx_q, vec_idx_d;
    logic              loaded_q,  loaded_d;   // PC was just loaded; first FETCH must not increment
    logic [3:0]        cnt_q,     cnt_d;      // operand bytes left / memory-wait cycles left
`ifdef PC_EPC_EN
    logic [ADDR_W-1:0] epc_q,     epc_d;
`endif

    logic              is_jmp_call;
    logic              is_ret;
    logic [1:0]        extra_clamped;
    logic [2:0]        irq_slot;
    logic              irq_any;

    assign is_jmp_call   = (opcode_i == OP_BRX) && !brx_i[1];
    assign is_ret        = (opcode_i == OP_BRX) &&  brx_i[1];
    assign extra_clamped = (extra_bytes_i > MAX_EXTRA_C) ? MAX_EXTRA_C : extra_bytes_i;
    assign irq_any       = |irq_i;

    // Lowest set request line wins; scanning downwards lets the lowest index overwrite.
    always_comb begin
        irq_slot = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_i[i]) irq_slot = 3'(i + 1);
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        pc_d      = pc_q;
        vec_idx_d = vec_idx_q;
        loaded_d  = loaded_q;
        cnt_d     = cnt_q;
`ifdef PC_EPC_EN
        epc_d     = epc_q;
`endif
        pc_en_o   = 1'b0;
        pc_load_o = 1'b0;
        pc_src_o  = SRC_EX;
        stall_o   = 1'b0;
        irq_ack_o = '0;

        case (state_q)
            S_VECTOR: begin
                pc_en_o   = 1'b1;
                pc_load_o = 1'b1;
                pc_src_o  = SRC_VEC;
                pc_d      = vec_data_i;
                loaded_d  = 1'b1;
                state_d   = S_FETCH;
                for (int i = 0; i < NUM_IRQ; i++) begin
                    if (vec_idx_q == 3'(i + 1)) irq_ack_o[i] = 1'b1;
                end
`ifdef PC_EPC_EN
                // pc_q still holds the next unexecuted instruction here.
                if (vec_idx_q != 3'd0) epc_d = pc_q;
`endif
            end

            S_FETCH: begin
                pc_en_o  = !loaded_q;
                if (!loaded_q) pc_d = pc_q + 1'b1;
                loaded_d = 1'b0;
                // Interrupts only at an instruction boundary, ahead of everything else.
                if (irq_any) begin
                    state_d   = S_VECTOR;
                    vec_idx_d = irq_slot;
                end else if (extra_clamped != 2'd0) begin
                    state_d = S_OPERAND;
                    cnt_d   = {2'b00, extra_clamped};
                end else if (branch_taken_i || is_jmp_call) begin
                    state_d = S_BRANCH;
                end else if (is_ret) begin
                    state_d = S_WAIT;
                    cnt_d   = MEM_LAT_C;
                end
            end

            S_OPERAND: begin
                pc_en_o = 1'b1;
                pc_d    = pc_q + 1'b1;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == 4'd1) begin
                    state_d  = S_FETCH;
                    loaded_d = 1'b0;
                end
            end

            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    stall_o = 1'b1;
                    cnt_d   = cnt_q - 1'b1;
                end else begin
                    state_d = S_BRANCH;
                end
            end

            S_BRANCH: begin
                state_d = S_FETCH;
                if (branch_taken_i) begin
                    pc_en_o   = 1'b1;
                    pc_load_o = 1'b1;
                    pc_src_o  = SRC_EX;
                    pc_d      = rb_ex_i;
                    loaded_d  = 1'b1;
                end else if (is_jmp_call) begin
                    if (tgt_ready_i) begin
                        pc_en_o   = 1'b1;
                        pc_load_o = 1'b1;
                        pc_src_o  = SRC_D;
                        pc_d      = rb_d_i;
                        loaded_d  = 1'b1;
                    end else begin
                        // Decode has not resolved the target yet: hold here.
                        stall_o = 1'b1;
                        state_d = S_BRANCH;
                    end
                end else if (is_ret) begin
                    pc_en_o   = 1'b1;
                    pc_load_o = 1'b1;
                    pc_src_o  = SRC_MEM;
                    pc_d      = mem_data_i;
                    loaded_d  = 1'b1;
                end
            end

            default: state_d = S_FETCH;   // unreachable encodings recover at a boundary
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset_i) begin
            state_q   <= S_VECTOR;
            pc_q      <= '0;
            vec_idx_q <= 3'd0;
            loaded_q  <= 1'b1;
            cnt_q     <= 4'd0;
`ifdef PC_EPC_EN
            epc_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            vec_idx_q <= vec_idx_d;
            loaded_q  <= loaded_d;
            cnt_q     <= cnt_d;
`ifdef PC_EPC_EN
            epc_q     <= epc_d;
`endif
        end
    end

    assign pc_o      = pc_q;
    assign vec_idx_o = vec_idx_q;
`ifdef PC_EPC_EN
    assign epc_o     = epc_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Self-checking bench for pc_sequencer (ADDR_W=8, MEM_LAT=3, MAX_EXTRA=2,
// NUM_IRQ=3). A behavioural model of the sequencing rules predicts every
// output each cycle; directed scenarios are followed by randomized traffic.
// ----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam int ADDR_W    = 8;
    localparam int MEM_LAT   = 3;
    localparam int MAX_EXTRA = 2;
    localparam int NUM_IRQ   = 3;
    localparam int PC_MOD    = 1 << ADDR_W;

    logic               clk = 1'b0;
    logic               reset_i;
    logic [NUM_IRQ-1:0] irq_i;
    logic [3:0]         opcode_i;
    logic [1:0]         brx_i;
    logic [1:0]         extra_bytes_i;
    logic               branch_taken_i;
    logic               tgt_ready_i;
    logic [ADDR_W-1:0]  rb_ex_i, rb_d_i, mem_data_i, vec_data_i;
    logic [ADDR_W-1:0]  pc_o;
    logic               pc_en_o, pc_load_o, stall_o;
    logic [1:0]         pc_src_o;
    logic [2:0]         vec_idx_o;
    logic [NUM_IRQ-1:0] irq_ack_o;
`ifdef PC_EPC_EN
    logic [ADDR_W-1:0]  epc_o;
`endif

    always #5 clk = ~clk;

    pc_sequencer #(
        .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .MAX_EXTRA(MAX_EXTRA), .NUM_IRQ(NUM_IRQ)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .irq_i(irq_i), .opcode_i(opcode_i),
        .brx_i(brx_i), .extra_bytes_i(extra_bytes_i), .branch_taken_i(branch_taken_i),
        .tgt_ready_i(tgt_ready_i), .rb_ex_i(rb_ex_i), .rb_d_i(rb_d_i),
        .mem_data_i(mem_data_i), .vec_data_i(vec_data_i), .pc_o(pc_o),
        .pc_en_o(pc_en_o), .pc_load_o(pc_load_o), .pc_src_o(pc_src_o),
        .vec_idx_o(vec_idx_o), .irq_ack_o(irq_ack_o), .stall_o(stall_o)
`ifdef PC_EPC_EN
        , .epc_o(epc_o)
`endif
    );

    // Reference model: what the sequencer is doing, in plain terms.
    typedef enum {PH_VEC, PH_FETCH, PH_OPER, PH_MEMWAIT, PH_BR} phase_t;
    phase_t m_ph    = PH_VEC;
    int     m_pc    = 0;
    int     m_slot  = 0;
    int     m_left  = 0;
    int     m_epc   = 0;
    bit     m_fresh = 1'b1;   // PC freshly loaded, next fetch does not advance

    int n_cmp = 0;
    int n_bad = 0;

    // Outputs seen at the last sampled cycle, for scenario-level checks.
    logic               obs_en, obs_load, obs_stall;
    logic [1:0]         obs_src;
    logic [2:0]         obs_vidx;
    logic [NUM_IRQ-1:0] obs_ack;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        reset_i        = 1'b0;
        irq_i          = '0;
        opcode_i       = 4'd0;
        brx_i          = 2'd0;
        extra_bytes_i  = 2'd0;
        branch_taken_i = 1'b0;
        tgt_ready_i    = 1'b0;
    endtask

    // One clock cycle: predict outputs from the model and current inputs,
    // compare on the falling edge, then advance the model past the rising edge.
    task automatic cyc(input bit chk);
        phase_t nx_ph;
        int     nx_pc, nx_slot, nx_left, nx_epc, first, xb;
        bit     nx_fresh, e_en, e_load, e_stall, is_br, jc, ret;
        int     e_src, e_ack;

        nx_ph = m_ph; nx_pc = m_pc; nx_slot = m_slot; nx_left = m_left;
        nx_epc = m_epc; nx_fresh = m_fresh;
        e_en = 0; e_load = 0; e_stall = 0; e_src = 0; e_ack = 0;

        first = -1;
        for (int i = 0; i < NUM_IRQ; i++)
            if (irq_i[i] && first < 0) first = i;
        xb    = (int'(extra_bytes_i) > MAX_EXTRA) ? MAX_EXTRA : int'(extra_bytes_i);
        is_br = (opcode_i == 4'd11);
        jc    = is_br && (brx_i < 2'd2);
        ret   = is_br && (brx_i >= 2'd2);

        case (m_ph)
            PH_VEC: begin
                e_en = 1; e_load = 1; e_src = 1;
                if (m_slot != 0) begin
                    e_ack  = 1 << (m_slot - 1);
                    nx_epc = m_pc;
                end
                nx_pc = int'(vec_data_i); nx_fresh = 1; nx_ph = PH_FETCH;
            end
            PH_FETCH: begin
                e_en = !m_fresh;
                if (!m_fresh) nx_pc = (m_pc + 1) % PC_MOD;
                nx_fresh = 0;
                if (first >= 0) begin
                    nx_ph = PH_VEC; nx_slot = first + 1;
                end else if (xb > 0) begin
                    nx_ph = PH_OPER; nx_left = xb;
                end else if (branch_taken_i || jc) begin
                    nx_ph = PH_BR;
                end else if (ret) begin
                    nx_ph = PH_MEMWAIT; nx_left = MEM_LAT;
                end
            end
            PH_OPER: begin
                e_en = 1; nx_pc = (m_pc + 1) % PC_MOD; nx_left = m_left - 1;
                if (m_left == 1) begin nx_ph = PH_FETCH; nx_fresh = 0; end
            end
            PH_MEMWAIT: begin
                if (m_left != 0) begin e_stall = 1; nx_left = m_left - 1; end
                else nx_ph = PH_BR;
            end
            PH_BR: begin
                nx_ph = PH_FETCH;
                if (branch_taken_i) begin
                    e_load = 1; e_src = 0; nx_pc = int'(rb_ex_i);
                end else if (jc) begin
                    if (tgt_ready_i) begin e_load = 1; e_src = 2; nx_pc = int'(rb_d_i); end
                    else begin e_stall = 1; nx_ph = PH_BR; end
                end else if (ret) begin
                    e_load = 1; e_src = 3; nx_pc = int'(mem_data_i);
                end
                if (e_load) begin e_en = 1; nx_fresh = 1; end
            end
            default: ;
        endcase

        if (reset_i) begin
            nx_ph = PH_VEC; nx_pc = 0; nx_slot = 0; nx_left = 0; nx_epc = 0; nx_fresh = 1;
        end

        @(negedge clk);
        if (chk) begin
            check("pc",      pc_o,      m_pc);
            check("pc_en",   pc_en_o,   e_en);
            check("pc_load", pc_load_o, e_load);
            check("pc_src",  pc_src_o,  e_src);
            check("vec_idx", vec_idx_o, m_slot);
            check("irq_ack", irq_ack_o, e_ack);
            check("stall",   stall_o,   e_stall);
`ifdef PC_EPC_EN
            check("epc",     epc_o,     m_epc);
`endif
        end
        obs_en = pc_en_o; obs_load = pc_load_o; obs_stall = stall_o;
        obs_src = pc_src_o; obs_vidx = vec_idx_o; obs_ack = irq_ack_o;

        @(posedge clk);
        #1;
        m_ph = nx_ph; m_pc = nx_pc; m_slot = nx_slot; m_left = nx_left;
        m_epc = nx_epc; m_fresh = nx_fresh;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n_stall;
        bit  got_load;
        logic [1:0] load_src;
        logic [NUM_IRQ-1:0] ack_or;

        idle();
        rb_ex_i = '0; rb_d_i = '0; mem_data_i = '0; vec_data_i = 8'h40;

        // 1: reset, vector 0 load, first fetch does not advance.
        reset_i = 1'b1;
        cyc(0);
        cyc(1);
        reset_i = 1'b0;
        cyc(1);
        check("t1_pc_after_vector", pc_o, 8'h40);
        cyc(1);
        check("t1_first_fetch_en", obs_en, 1'b0);
        cyc(1);
        check("t1_second_fetch_pc", pc_o, 8'h41);

        // 2: jump to 0x0F, walk to 0x10, then a 2-operand instruction.
        opcode_i = 4'd11; brx_i = 2'd0; tgt_ready_i = 1'b1; rb_d_i = 8'h0F;
        cyc(1);
        cyc(1);
        check("t2_jmp_pc", pc_o, 8'h0F);
        idle();
        cyc(1);
        cyc(1);
        check("t2_pc_at_fetch", pc_o, 8'h10);
        extra_bytes_i = 2'd2;
        n_stall = 0;
        cyc(1); n_stall += int'(obs_stall);
        extra_bytes_i = 2'd0;
        cyc(1); n_stall += int'(obs_stall); check("t2_oper1_en", obs_en, 1'b1);
        cyc(1); n_stall += int'(obs_stall); check("t2_oper2_en", obs_en, 1'b1);
        check("t2_pc_after_operands", pc_o, 8'h13);
        check("t2_no_stall", n_stall, 0);

        // 3: RET with memory wait.
        opcode_i = 4'd11; brx_i = 2'd2; mem_data_i = 8'h7A;
        n_stall = 0; got_load = 0; load_src = 2'd0;
        for (int k = 0; k < 12 && !got_load; k++) begin
            cyc(1);
            if (obs_stall) n_stall++;
            if (obs_load) begin got_load = 1; load_src = obs_src; end
        end
        check("t3_load_seen", got_load, 1'b1);
        check("t3_stall_cycles", n_stall, MEM_LAT);
        check("t3_src", load_src, 2'b11);
        check("t3_pc", pc_o, 8'h7A);

        // 4: JMP with late target.
        opcode_i = 4'd11; brx_i = 2'd0; tgt_ready_i = 1'b0; rb_d_i = 8'h22;
        cyc(1);
        n_stall = 0;
        repeat (4) begin cyc(1); n_stall += int'(obs_stall); end
        check("t4_stall_cycles", n_stall, 4);
        tgt_ready_i = 1'b1;
        cyc(1);
        check("t4_load", obs_load, 1'b1);
        check("t4_src", obs_src, 2'b10);
        check("t4_pc", pc_o, 8'h22);

        // 5: interrupt raised during RTI wait is held off until FETCH.
        opcode_i = 4'd11; brx_i = 2'd3; tgt_ready_i = 1'b0; mem_data_i = 8'h55;
        cyc(1);
        irq_i = 3'b110;
        ack_or = '0;
        repeat (MEM_LAT + 2) begin cyc(1); ack_or |= obs_ack; end
        check("t5_no_early_ack", ack_or, 3'b000);
        check("t5_pc_after_rti", pc_o, 8'h55);
        opcode_i = 4'd0; brx_i = 2'd0; vec_data_i = 8'h90;
        cyc(1);
        check("t5_vec_idx", vec_idx_o, 3'd2);
        cyc(1);
        check("t5_ack", obs_ack, 3'b010);
        check("t5_pc_vector", pc_o, 8'h90);
`ifdef PC_EPC_EN
        check("t5_epc", epc_o, 8'h55);
`endif
        irq_i = '0;
        cyc(1);
        check("t5_ack_one_cycle", obs_ack, 3'b000);

        // 6: wrap at 0xFF, then reset in the middle of OPERAND.
        opcode_i = 4'd11; brx_i = 2'd0; tgt_ready_i = 1'b1; rb_d_i = 8'hFE;
        cyc(1);
        cyc(1);
        idle();
        cyc(1);
        cyc(1);
        check("t6_pc_ff", pc_o, 8'hFF);
        cyc(1);
        check("t6_pc_wrap", pc_o, 8'h00);
        check("t6_wrap_no_load", obs_load, 1'b0);
        extra_bytes_i = 2'd3;   // clamped to MAX_EXTRA
        cyc(1);
        extra_bytes_i = 2'd0;
        reset_i = 1'b1;
        cyc(1);
        check("t6_reset_pc", pc_o, 8'h00);
        check("t6_reset_vec_idx", vec_idx_o, 3'd0);
        reset_i = 1'b0; vec_data_i = 8'h40;
        cyc(1);
        check("t6_pc_vector_after_reset", pc_o, 8'h40);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            reset_i        = ($urandom_range(0, 99) == 0);
            irq_i          = ($urandom_range(0, 15) == 0) ? NUM_IRQ'($urandom) : '0;
            opcode_i       = ($urandom_range(0, 2) == 0) ? 4'd11 : 4'($urandom);
            brx_i          = 2'($urandom);
            extra_bytes_i  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
            branch_taken_i = ($urandom_range(0, 7) == 0);
            tgt_ready_i    = ($urandom_range(0, 2) != 0);
            rb_ex_i        = 8'($urandom);
            rb_d_i         = 8'($urandom);
            mem_data_i     = 8'($urandom);
            vec_data_i     = 8'($urandom);
            cyc(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
